// File: rtl/nyq_pkg.sv
// rtl/nyq_pkg.sv - shared constants and saturation helper for the nyq pulse-shaping filter
package nyq_pkg;

    localparam int COEF_WIDTH     = 16;
    localparam int CTRL_ADDR      = 0;
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_SHIFT_LSB = 1;
    localparam int CTRL_SHIFT_W   = 5;

    // Clamp a signed value into the w-bit two's-complement range (w <= 64).
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/nyq_regfile.sv
// rtl/nyq_regfile.sv - parameter memory (CTRL + coefficients), async clear, all words exposed in parallel
module nyq_regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [MEM_WIDTH-1:0]  wr_data,
    output logic [MEM_WIDTH-1:0]  words [2**ADDR_WIDTH]
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                words[k] <= '0;
            end
        end else if (wr_en) begin
            words[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/nyq.sv
// rtl/nyq.sv - programmable raised-cosine FIR, one sample per clock; NYQ_ROUND_EN selects round-half-up before shift
module nyq
    import nyq_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24
) (
    input  logic                        Clk_CI,
    input  logic                        Rst_RBI,
    input  logic                        WrEn_SI,
    input  logic [ADDR_WIDTH-1:0]       Addr_DI,
    input  logic [MEM_WIDTH-1:0]        PAR_In_DI,
    input  logic signed [IN_WIDTH-1:0]  NYQ_In_DI,
    output logic signed [OUT_WIDTH-1:0] NYQ_Out_DO
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int NUM_TAPS = DEPTH - 1;
    localparam int ACC_W    = IN_WIDTH + COEF_WIDTH + ADDR_WIDTH;

    logic [MEM_WIDTH-1:0]        words [DEPTH];
    logic signed [IN_WIDTH-1:0]  x [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0] coef [NUM_TAPS];
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     acc_rnd;
    logic signed [ACC_W-1:0]     acc_shr;
    logic [CTRL_SHIFT_W-1:0]     shift;
    logic                        en;
    logic signed [63:0]          sat_v;
    logic signed [OUT_WIDTH-1:0] y;
    logic                        unused_bits;

    nyq_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_WIDTH  (MEM_WIDTH)
    ) u_regfile (
        .clk     (Clk_CI),
        .rst_n   (Rst_RBI),
        .wr_en   (WrEn_SI),
        .addr    (Addr_DI),
        .wr_data (PAR_In_DI),
        .words   (words)
    );

    assign en    = words[CTRL_ADDR][CTRL_EN_BIT];
    assign shift = words[CTRL_ADDR][CTRL_SHIFT_LSB +: CTRL_SHIFT_W];

    // Full-precision MAC: every product is sign-extended to the accumulator width first.
    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            coef[k] = words[k+1][COEF_WIDTH-1:0];
            acc     = acc + ACC_W'(coef[k]) * ACC_W'(x[k]);
        end
`ifdef NYQ_ROUND_EN
        acc_rnd = (shift != '0) ? acc + (ACC_W'(1) <<< (shift - 1'b1)) : acc;
`else
        acc_rnd = acc;
`endif
        acc_shr = acc_rnd >>> shift;
        sat_v   = en ? saturate(64'(acc_shr), OUT_WIDTH) : saturate(64'(x[0]), OUT_WIDTH);
        y       = sat_v[OUT_WIDTH-1:0];
    end

    always_comb begin
        unused_bits = ^sat_v;
        for (int k = 0; k < DEPTH; k++) begin
            unused_bits = unused_bits ^ (^words[k]);
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x[k] <= '0;
            end
            NYQ_Out_DO <= '0;
        end else begin
            x[0] <= NYQ_In_DI;
            for (int k = 1; k < NUM_TAPS; k++) begin
                x[k] <= x[k-1];
            end
            NYQ_Out_DO <= y;
        end
    end

endmodule

// File: tb/tb_nyq.sv
// tb/tb_nyq.sv - self-checking bench for nyq: directed cases plus randomized traffic against a reference model
module tb_nyq;

    localparam int AW    = 5;
    localparam int MW    = 32;
    localparam int IW    = 24;
    localparam int OW    = 24;
    localparam int DEPTH = 32;
    localparam int TAPS  = 31;

    logic                 clk;
    logic                 rst_n;
    logic                 wr_en;
    logic [AW-1:0]        addr;
    logic [MW-1:0]        par_in;
    logic signed [IW-1:0] nyq_in;
    logic signed [OW-1:0] nyq_out;

    int vectors;
    int miscompares;

    logic [31:0] mem_m [DEPTH];
    longint      x_m   [TAPS];

    nyq #(
        .ADDR_WIDTH (AW),
        .MEM_WIDTH  (MW),
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (OW)
    ) dut (
        .Clk_CI     (clk),
        .Rst_RBI    (rst_n),
        .WrEn_SI    (wr_en),
        .Addr_DI    (addr),
        .PAR_In_DI  (par_in),
        .NYQ_In_DI  (nyq_in),
        .NYQ_Out_DO (nyq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
        for (int k = 0; k < TAPS; k++) x_m[k] = 0;
    endtask

    // Output value the filter should present after the next edge, from the state before it.
    function automatic longint model_y();
        longint acc;
        longint v;
        int     sh;
        sh = int'((mem_m[0] >> 1) & 32'd31);
        if (mem_m[0][0] == 1'b0) begin
            v = x_m[0];
        end else begin
            acc = 0;
            for (int k = 0; k < TAPS; k++) begin
                acc += longint'($signed(mem_m[k+1][15:0])) * x_m[k];
            end
`ifdef NYQ_ROUND_EN
            if (sh > 0) acc += longint'(1) << (sh - 1);
`endif
            v = acc >>> sh;
        end
        if (v > 64'sd8388607) v = 8388607;
        if (v < -64'sd8388608) v = -8388608;
        return v;
    endfunction

    task automatic step(input bit we, input int a, input logic [31:0] d, input int sin, input string tag);
        longint exp;
        logic [31:0] s;
        wr_en  = we;
        addr   = a[AW-1:0];
        par_in = d;
        s      = sin;
        nyq_in = s[IW-1:0];
        exp    = model_y();
        if (we) mem_m[a] = d;
        for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
        x_m[0] = longint'(sin);
        @(posedge clk);
        #1;
        check(tag, longint'(nyq_out), exp);
    endtask

    task automatic flush();
        for (int i = 0; i < TAPS + 1; i++) step(1'b0, 0, 32'd0, 0, "flush");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        wr_en  = 1'b0;
        addr   = '0;
        par_in = '0;
        nyq_in = 24'sd100;
        model_reset();

        // 1: reset hold, then bypass
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", longint'(nyq_out), 0);
        rst_n = 1'b1;
        step(1'b0, 0, 32'd0, 100, "byp_fill");
        check("byp_first", longint'(nyq_out), 0);
        step(1'b0, 0, 32'd0, 100, "byp");
        check("byp_100", longint'(nyq_out), 100);

        // 2: impulse response
        flush();
        step(1'b1, 0, 32'd1, 0, "wr_ctrl");
        step(1'b1, 1, 32'd1, 0, "wr_c0");
        step(1'b1, 2, 32'd2, 0, "wr_c1");
        step(1'b1, 3, 32'd3, 0, "wr_c2");
        step(1'b0, 0, 32'd0, 1000, "imp_in");
        step(1'b0, 0, 32'd0, 0, "imp0");
        check("imp_1000", longint'(nyq_out), 1000);
        step(1'b0, 0, 32'd0, 0, "imp1");
        check("imp_2000", longint'(nyq_out), 2000);
        step(1'b0, 0, 32'd0, 0, "imp2");
        check("imp_3000", longint'(nyq_out), 3000);
        step(1'b0, 0, 32'd0, 0, "imp3");
        check("imp_0", longint'(nyq_out), 0);

        // 3: saturation at both rails
        step(1'b1, 2, 32'd0, 0, "wr_c1z");
        step(1'b1, 3, 32'd0, 0, "wr_c2z");
        step(1'b1, 1, 32'd32767, 0, "wr_c0max");
        step(1'b0, 0, 32'd0, 8388607, "sat_pin");
        step(1'b0, 0, 32'd0, -8388608, "sat_nin");
        check("sat_pos", longint'(nyq_out), 8388607);
        step(1'b0, 0, 32'd0, 0, "sat_z");
        check("sat_neg", longint'(nyq_out), -8388608);

        // 4: shift by one, truncate or round
        step(1'b1, 0, 32'd3, 0, "wr_ctrl_sh1");
        step(1'b1, 1, 32'd3, 0, "wr_c0_3");
        step(1'b0, 0, 32'd0, 5, "sh_p5");
        step(1'b0, 0, 32'd0, -5, "sh_n5");
`ifdef NYQ_ROUND_EN
        check("shift_p", longint'(nyq_out), 8);
`else
        check("shift_p", longint'(nyq_out), 7);
`endif
        step(1'b0, 0, 32'd0, 0, "sh_z");
`ifdef NYQ_ROUND_EN
        check("shift_n", longint'(nyq_out), -7);
`else
        check("shift_n", longint'(nyq_out), -8);
`endif

        // 5: live coefficient rewrite under constant input
        step(1'b1, 0, 32'd1, 10, "wr_ctrl_en");
        step(1'b1, 1, 32'd1, 10, "wr_c0_1");
        step(1'b0, 0, 32'd0, 10, "const");
        step(1'b0, 0, 32'd0, 10, "const");
        check("const_10", longint'(nyq_out), 10);
        step(1'b1, 1, 32'd4, 10, "wr_c0_4");
        check("pre_step", longint'(nyq_out), 10);
        step(1'b0, 0, 32'd0, 10, "post");
        check("post_step", longint'(nyq_out), 40);

        // 6: asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", longint'(nyq_out), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 0, 32'd0, 7, "rst_in7");
        step(1'b0, 0, 32'd0, 7, "rst_out");
        check("rst_byp7", longint'(nyq_out), 7);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit          we;
            int          a;
            logic [31:0] d;
            int          sin;
            we = ($urandom_range(0, 3) == 0);
            a  = $urandom_range(0, DEPTH - 1);
            d  = $urandom;
            if (a == 0) begin
                d[5:1] = 5'($urandom_range(0, 20));
                if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
            end else if ($urandom_range(0, 1) == 0) begin
                d[15:0] = 16'($signed($urandom_range(0, 512)) - 256);
            end
            if ($urandom_range(0, 3) == 0) sin = $urandom_range(0, 16777215) - 8388608;
            else sin = $urandom_range(0, 2000) - 1000;
            step(we, a, d, sin, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
